alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Instruction-issue side of the ALU. Accepts 16-bit instruction words over a valid/ready handshake,
//  decodes them, and reads operands from a 16x16 register file. Drives op/a/b into the combinational
//  ALU, captures its result and writes it back. One instruction in flight; sits between fetch and ALU.
// PARAMETERS
//  DW     16  datapath / register width
//  NREGS  16  register file depth (register fields are log2(NREGS)=4 bits)
// PORTS
//  clock        in   1   system clock, all state on rising edge
//  reset_n      in   1   synchronous, active-low reset
//  instr_valid  in   1   instr_data valid
//  instr_data   in   16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt
//  instr_ready  out  1   high only in IDLE; transfer when valid&ready at clock edge
//  alu_op       out  4   registered op to ALU
//  alu_a        out  DW  registered operand a (reg[rs])
//  alu_b        out  DW  registered operand b (reg[rt])
//  alu_result   in   DW  combinational ALU output
//  wb_valid     out  1   one-cycle pulse: write-back this cycle
//  wb_addr      out  4   destination register (valid with wb_valid)
//  wb_data      out  DW  write-back data (valid with wb_valid)
//  illegal      out  1   one-cycle pulse: undefined opcode dropped
//  dbg_addr     in   4   debug read address
//  dbg_data     out  DW  reg[dbg_addr], combinational read
// BEHAVIOUR
//  - Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 EPAR (even parity of a[15:0] -> 16'h0000/16'h0001),
//    4'hF LDI (rd <= {8'h00, instr[7:0]}, ALU bypassed), 5..E illegal.
//  - FSM IDLE -> DECODE -> EXEC -> WB -> IDLE.
//    IDLE: instr_ready=1; on valid&ready latch instr_data, go DECODE.
//    DECODE: illegal opcode -> illegal=1 next cycle, back to IDLE, no write. Else register
//      alu_op=opcode, alu_a=reg[rs], alu_b=reg[rt]; go EXEC.
//    EXEC: ALU inputs stable; sample alu_result (LDI: immediate) into wb_data at end of cycle; go WB.
//    WB: wb_valid=1, reg[rd]<=wb_data at end of cycle; go IDLE.
//  - Latency: accept edge -> wb_valid high 3 cycles later. Throughput 1 instr / 4 cycles.
//  - Illegal: pulse 2 cycles after accept, ready again the cycle after.
//  - Arithmetic wraps mod 2^16, no carry/overflow. rs, rt, rd may alias.
//  - Next DECODE sees the prior WB's value; no hazards, since issue is serialized.
//  - instr_valid outside IDLE ignored; instr_data need not be held after accept.
//  - alu_op/alu_a/alu_b hold values between instructions.
//  - Reset (any state, incl. mid-instruction): FSM->IDLE, in-flight instr discarded, all 16 regs=0.
//    alu_op=0, alu_a=alu_b=0, wb_valid=0, wb_addr=0, wb_data=0, illegal=0.
//    instr_ready=1 in the first cycle after reset deasserts.
// CONFIGURATION
//  ALU_ISSUE_ZFLAG_EN defined: extra port zero_flag out 1. Reset 0.
//    Updated in WB to (wb_data==0) for every written instruction, incl. LDI; held otherwise.
//  Undefined: no zero_flag port, no flag register; all other behaviour identical.
// STRUCTURE
//  - Shared include alu_defs.vh: opcode constants (ADD..EPAR, LDI), instruction field positions,
//    FSM state encodings.
//  - One sub-module, alu_issue_regfile: NREGS x DW, two combinational read ports (rs, rt),
//    one debug read port, one synchronous write port, synchronous active-low clear.
//  - The FSM and decode logic live in this module.
// TESTING
//  1. Reset, then LDI r1,0x34 (16'hF134) -> wb_valid 3 cycles after accept, wb_addr=1,
//     wb_data=16'h0034; dbg r1=16'h0034.
//  2. r1=0x34, r2=0x12; ADD r3,r1,r2 (16'h0312) -> alu_op=0, a=16'h0034, b=16'h0012, r3=16'h0046;
//     SUB r4,r2,r1 (16'h1421) -> r4=16'hFFDE (wrap).
//  3. r1=0x00F7: EPAR r5,r1,r1 (16'h4511) -> r5=16'h0001; r1=0x0003 -> r5=16'h0000.
//  4. Opcode 4'h7 (16'h7123) -> illegal pulses once, no wb_valid, all regs unchanged,
//     instr_ready high the following cycle.
//  5. Drop reset_n for one cycle during EXEC of ADD -> no wb_valid, all regs 0,
//     instr_ready=1 the next cycle; instr_valid held high during the busy states accepts only one instr.
//  6. ALU_ISSUE_ZFLAG_EN: r1=5, r2=5; SUB r3,r1,r2 -> zero_flag=1 after WB;
//     then LDI r3,1 -> zero_flag=0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg
//   Shared definitions for the ALU issue controller: datapath sizes, opcode
//   constants, instruction field layout, FSM state encoding and a small
//   opcode-legality helper.
//   Optional build macro used elsewhere in this slice: ALU_ISSUE_ZFLAG_EN.
package alu_issue_ctrl_pkg;

  localparam int DW_DEF    = 16;
  localparam int NREGS_DEF = 16;
  localparam int RAW       = 4;   // register field width in the instruction word

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_EPAR = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'hF;

  // Instruction word: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
  // For LDI the immediate is {rs, rt}.
  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_EPAR) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles the issue controller's instruction handshake, ALU drive/return,
//   write-back, illegal strobe and debug read port.
//   modport slave  : the issue controller itself
//   modport master : the surrounding fetch / ALU / debug environment
//   With ALU_ISSUE_ZFLAG_EN defined an extra zero_flag signal is present.
interface alu_issue_ctrl_if #(
  parameter int DW = 16
) ();

  logic          instr_valid;
  logic [15:0]   instr_data;
  logic          instr_ready;
  logic [3:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          wb_valid;
  logic [3:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          illegal;
  logic [3:0]    dbg_addr;
  logic [DW-1:0] dbg_data;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic          zero_flag;
`endif

  modport slave (
`ifdef ALU_ISSUE_ZFLAG_EN
    output zero_flag,
`endif
    input  instr_valid, instr_data, alu_result, dbg_addr,
    output instr_ready, alu_op, alu_a, alu_b,
    output wb_valid, wb_addr, wb_data, illegal, dbg_data
  );

  modport master (
`ifdef ALU_ISSUE_ZFLAG_EN
    input  zero_flag,
`endif
    output instr_valid, instr_data, alu_result, dbg_addr,
    input  instr_ready, alu_op, alu_a, alu_b,
    input  wb_valid, wb_addr, wb_data, illegal, dbg_data
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile
//   NREGS x DW register file for the issue controller.
//   Ports: clock, reset_n (synchronous active-low clear of every entry),
//   rs_addr/rs_data and rt_addr/rt_data (combinational operand reads),
//   dbg_addr/dbg_data (combinational debug read), we/wa/wd (synchronous write).
module alu_issue_regfile #(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wa] = wd;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rs_data  = mem_q[rs_addr];
  assign rt_data  = mem_q[rt_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Instruction-issue side of the ALU. Accepts one 16-bit instruction at a
//   time, reads operands from the register file, drives registered op/a/b to
//   the external combinational ALU, captures the result and writes it back.
//   Ports: clock, reset_n (synchronous active-low), bus (alu_issue_ctrl_if.slave:
//   instruction handshake, ALU op/a/b/result, write-back, illegal, debug read).
//   Build option ALU_ISSUE_ZFLAG_EN adds a registered zero_flag, updated on
//   every write-back.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | instr_ready high, waiting for instr_valid
//   ST_DECODE | check opcode; legal -> register op/a/b, illegal -> drop
//   ST_EXEC   | ALU inputs stable; capture result (or LDI immediate)
//   ST_WB     | wb_valid high, register file written at end of cycle
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_issue_ctrl_if.slave bus
);

  state_e        state_q,    state_d;
  instr_t        instr_q,    instr_d;
  logic [3:0]    alu_op_q,   alu_op_d;
  logic [DW-1:0] alu_a_q,    alu_a_d;
  logic [DW-1:0] alu_b_q,    alu_b_d;
  logic          wb_valid_q, wb_valid_d;
  logic [3:0]    wb_addr_q,  wb_addr_d;
  logic [DW-1:0] wb_data_q,  wb_data_d;
  logic          illegal_q,  illegal_d;
`ifdef ALU_ISSUE_ZFLAG_EN
  logic          zero_flag_q, zero_flag_d;
`endif

  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  alu_issue_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .rs_addr  (instr_q.rs),
    .rt_addr  (instr_q.rt),
    .dbg_addr (bus.dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (bus.dbg_data),
    .we       (state_q == ST_WB),
    .wa       (wb_addr_q),
    .wd       (wb_data_q)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;
`ifdef ALU_ISSUE_ZFLAG_EN
    zero_flag_d = zero_flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // instr_ready is high throughout IDLE, so valid alone is a transfer
        if (bus.instr_valid) begin
          instr_d = bus.instr_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!op_legal(instr_q.opc)) begin
          illegal_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          alu_op_d = instr_q.opc;
          alu_a_d  = rs_data;
          alu_b_d  = rt_data;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_addr_d  = instr_q.rd;
        wb_data_d  = (instr_q.opc == OP_LDI) ? DW'({instr_q.rs, instr_q.rt})
                                             : bus.alu_result;
        wb_valid_d = 1'b1;
        state_d    = ST_WB;
      end
      ST_WB: begin
`ifdef ALU_ISSUE_ZFLAG_EN
        zero_flag_d = (wb_data_q == '0);
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
`ifdef ALU_ISSUE_ZFLAG_EN
      zero_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
`ifdef ALU_ISSUE_ZFLAG_EN
      zero_flag_q <= zero_flag_d;
`endif
    end
  end

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.illegal     = illegal_q;
`ifdef ALU_ISSUE_ZFLAG_EN
  assign bus.zero_flag   = zero_flag_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl with an external ALU model, a register
//   reference model and a write-back scoreboard. Zero-flag steps are built
//   when ALU_ISSUE_ZFLAG_EN is defined.
module tb_alu_issue_ctrl;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #10 clock = ~clock;

  alu_issue_ctrl_if #(.DW(16)) bus ();

  alu_issue_ctrl #(.DW(16), .NREGS(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // external combinational ALU
  logic [15:0] alu_res;
  always_comb begin
    alu_res = 16'h0000;
    case (bus.alu_op)
      4'h0: alu_res = bus.alu_a + bus.alu_b;
      4'h1: alu_res = bus.alu_a - bus.alu_b;
      4'h2: alu_res = bus.alu_a & bus.alu_b;
      4'h3: alu_res = bus.alu_a | bus.alu_b;
      4'h4: alu_res = {15'h0000, ^bus.alu_a};
      default: alu_res = 16'h0000;
    endcase
  end
  assign bus.alu_result = alu_res;

  typedef struct {
    bit          ill;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] ref_regs [16];
  int total   = 0;
  int bad     = 0;
  int wb_seen = 0;
  int ill_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ins);
    exp_t        e;
    logic [15:0] a, b;
    a = ref_regs[ins[7:4]];
    b = ref_regs[ins[3:0]];
    e.ill  = 1'b0;
    e.addr = ins[11:8];
    e.data = 16'h0000;
    case (ins[15:12])
      4'h0: e.data = a + b;
      4'h1: e.data = a - b;
      4'h2: e.data = a & b;
      4'h3: e.data = a | b;
      4'h4: e.data = (^a) ? 16'h0001 : 16'h0000;
      4'hF: e.data = {8'h00, ins[7:0]};
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clock) begin
    exp_t e;
    if (bus.wb_valid === 1'b1) begin
      wb_seen++;
      chk("wb_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_kind", 32'(e.ill), 32'd0);
        chk("wb_addr", 32'(bus.wb_addr), 32'(e.addr));
        chk("wb_data", 32'(bus.wb_data), 32'(e.data));
      end
    end
    if (bus.illegal === 1'b1) begin
      ill_seen++;
      chk("ill_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ill_kind", 32'(e.ill), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_regs[i] = 16'h0000;
  endtask

  task automatic chk_reg(input int i);
    bus.dbg_addr = 4'(i);
    #1;
    chk($sformatf("dbg_r%0d", i), 32'(bus.dbg_data), 32'(ref_regs[i]));
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      bus.dbg_addr = 4'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(bus.dbg_data), 32'(ref_regs[i]));
    end
    tick();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ready_before_issue", 32'(bus.instr_ready), 32'd1);
  endtask

  // one instruction, checked cycle by cycle; returns in the IDLE cycle after
  task automatic run(input logic [15:0] ins);
    exp_t e;
    wait_ready();
    e = model(ins);
    bus.instr_valid = 1'b1;
    bus.instr_data  = ins;
    tick();
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'($urandom);
    sb.push_back(e);
    chk("decode_ready", 32'(bus.instr_ready), 32'd0);
    chk("decode_wb", 32'(bus.wb_valid), 32'd0);
    chk("decode_ill", 32'(bus.illegal), 32'd0);
    tick();
    if (e.ill) begin
      chk("ill_pulse", 32'(bus.illegal), 32'd1);
      chk("ill_no_wb", 32'(bus.wb_valid), 32'd0);
      tick();
      chk("ill_clear", 32'(bus.illegal), 32'd0);
      chk("ready_after_ill", 32'(bus.instr_ready), 32'd1);
      chk("ill_no_wb2", 32'(bus.wb_valid), 32'd0);
    end else begin
      chk("alu_op", 32'(bus.alu_op), 32'(ins[15:12]));
      chk("alu_a", 32'(bus.alu_a), 32'(ref_regs[ins[7:4]]));
      chk("alu_b", 32'(bus.alu_b), 32'(ref_regs[ins[3:0]]));
      chk("exec_wb", 32'(bus.wb_valid), 32'd0);
      tick();
      chk("wb_latency", 32'(bus.wb_valid), 32'd1);
      chk("wb_busy_ready", 32'(bus.instr_ready), 32'd0);
      tick();
      chk("wb_pulse_end", 32'(bus.wb_valid), 32'd0);
      chk("ready_after_wb", 32'(bus.instr_ready), 32'd1);
      ref_regs[e.addr] = e.data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb0;
    exp_t e;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 16'h0000;
    bus.dbg_addr    = 4'h0;
    clear_ref();

    // reset state
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
    chk("rst_wb_data", 32'(bus.wb_data), 32'd0);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("rst_zero_flag", 32'(bus.zero_flag), 32'd0);
`endif
    chk_regs("rst");

    // LDI, then arithmetic with wrap
    run(16'hF134);
    chk_reg(1);
    run(16'hF212);
    run(16'h0312);
    run(16'h1421);
    chk_reg(3);
    chk_reg(4);
    chk("sub_wrap_r4", 32'(ref_regs[4]), 32'h0000FFDE);
    run(16'h2512);
    run(16'h3612);
    chk_reg(5);
    chk_reg(6);

    // even parity
    run(16'hF1F7);
    run(16'h4511);
    chk_reg(5);
    run(16'hF103);
    run(16'h4511);
    chk_reg(5);

    // aliased operands and destination
    run(16'h0111);
    chk_reg(1);

    // illegal opcodes leave the register file alone
    run(16'h7123);
    chk_regs("ill7");
    run(16'hE123);
    chk_regs("illE");
    chk("alu_op_held", 32'(bus.alu_op), 32'd0);

    // valid held high through the busy states accepts exactly one instruction
    wait_ready();
    wb0 = wb_seen;
    e = model(16'h0312);
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h0312;
    tick();
    sb.push_back(e);
    bus.instr_data = 16'hF9AA;
    tick();
    tick();
    tick();
    bus.instr_valid = 1'b0;
    chk("held_ready_idle", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("held_no_second", 32'(bus.instr_ready), 32'd1);
    tick();
    chk("held_one_wb", 32'(wb_seen - wb0), 32'd1);
    ref_regs[e.addr] = e.data;
    chk_reg(3);

    // reset asserted for one cycle during EXEC
    wait_ready();
    wb0 = wb_seen;
    bus.instr_valid = 1'b1;
    bus.instr_data  = 16'h0712;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    clear_ref();
    chk("midrst_ready", 32'(bus.instr_ready), 32'd1);
    chk("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midrst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("midrst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("midrst_wb_data", 32'(bus.wb_data), 32'd0);
    chk_regs("midrst");
    tick();
    chk("midrst_no_wb", 32'(wb_seen - wb0), 32'd0);
    run(16'hF1AB);
    chk_reg(1);

    // zero flag follows every write-back
    run(16'hF105);
    run(16'hF205);
    run(16'h1312);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("zflag_set", 32'(bus.zero_flag), 32'd1);
`endif
    run(16'hF301);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("zflag_clear", 32'(bus.zero_flag), 32'd0);
    run(16'h7000);
    chk("zflag_held_ill", 32'(bus.zero_flag), 32'd0);
`endif
    chk_reg(3);

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
`ifdef ALU_ISSUE_ZFLAG_EN
    chk("ill_count", 32'(ill_seen), 32'd3);
`else
    chk("ill_count", 32'(ill_seen), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
